// File: rtl/grid_renderer.sv
// Raster renderer for side-by-side game boards: walks the pixel stream with incremental
// counters, fetches each cell's code from board RAM and paints grid, cursor and content colours.
module grid_renderer #(
    parameter int GRID_ROWS    = 10,
    parameter int GRID_COLS    = 10,
    parameter int CELL_SIZE    = 32,
    parameter int NUM_BOARDS   = 2,
    parameter int BOARD_GAP    = 32,
    parameter int BLINK_FRAMES = 30,
    localparam int BW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          sof,
    input  logic          sol,
    input  logic [1:0]    mode,
    input  logic [BW-1:0] own_board,
    input  logic [BW-1:0] cursor_board,
    input  logic [3:0]    cursor_x,
    input  logic [3:0]    cursor_y,
    input  logic [3:0]    ship_len,
    input  logic          orient,
    output logic [BW-1:0] rd_board,
    output logic [3:0]    rd_row,
    output logic [3:0]    rd_col,
    input  logic [1:0]    rd_data,
    output logic          rgb_valid,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b
);

    localparam int PW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam int GW = (BOARD_GAP > 1) ? $clog2(BOARD_GAP) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SHIP  = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        CUR_NONE,
        CUR_ATTACK,
        CUR_FIT,
        CUR_BAD
    } cursor_t;

    logic [PW-1:0] px, n_px, py, n_py;
    logic [3:0]    cell_x, n_cell_x, cell_y, n_cell_y;
    logic [BW-1:0] board, n_board;
    logic [GW-1:0] gap_cnt, n_gap;
    logic          in_gap, n_in_gap, past_end, n_past_end, y_out, n_y_out;

    logic [FW-1:0] frame_cnt, n_frame_cnt;
    logic          blink_phase, n_blink, started, n_started;

    logic          s1_valid, s1_blink, s1_orient;
    logic [1:0]    s1_mode;
    logic [BW-1:0] s1_own_board, s1_cursor_board;
    logic [3:0]    s1_cursor_x, s1_cursor_y, s1_ship_len;

    logic          s2_valid, s2_oog, s2_line, s2_fog, s2_blink;
    cursor_t       s2_cursor;

    // Position of the pixel presented this cycle, derived from the previous pixel's position.
    always_comb begin
        n_px       = px;
        n_cell_x   = cell_x;
        n_board    = board;
        n_gap      = gap_cnt;
        n_in_gap   = in_gap;
        n_past_end = past_end;
        n_py       = py;
        n_cell_y   = cell_y;
        n_y_out    = y_out;
        if (sof || sol) begin
            n_px       = '0;
            n_cell_x   = '0;
            n_board    = '0;
            n_gap      = '0;
            n_in_gap   = 1'b0;
            n_past_end = 1'b0;
            if (sof) begin
                n_py     = '0;
                n_cell_y = '0;
                n_y_out  = 1'b0;
            end else if (!y_out) begin
                if (py == PW'(CELL_SIZE - 1)) begin
                    n_py = '0;
                    if (cell_y == 4'(GRID_ROWS - 1)) n_y_out = 1'b1;
                    else n_cell_y = cell_y + 4'd1;
                end else begin
                    n_py = py + 1'b1;
                end
            end
        end else if (in_gap) begin
            if (gap_cnt == GW'(BOARD_GAP - 1)) begin
                n_in_gap = 1'b0;
                n_gap    = '0;
                n_board  = board + 1'b1;
            end else begin
                n_gap = gap_cnt + 1'b1;
            end
        end else if (!past_end) begin
            if (px == PW'(CELL_SIZE - 1)) begin
                n_px = '0;
                if (cell_x == 4'(GRID_COLS - 1)) begin
                    n_cell_x = '0;
                    if (board == BW'(NUM_BOARDS - 1)) n_past_end = 1'b1;
                    else if (BOARD_GAP == 0) n_board = board + 1'b1;
                    else n_in_gap = 1'b1;
                end else begin
                    n_cell_x = cell_x + 4'd1;
                end
            end else begin
                n_px = px + 1'b1;
            end
        end
    end

    // The very first frame start after reset is frame 0, so it only arms the counter.
    always_comb begin
        n_frame_cnt = frame_cnt;
        n_blink     = blink_phase;
        n_started   = started;
        if (pix_en && sof) begin
            if (!started) begin
                n_started = 1'b1;
            end else if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                n_frame_cnt = '0;
                n_blink     = ~blink_phase;
            end else begin
                n_frame_cnt = frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px              <= '0;
            cell_x          <= '0;
            board           <= '0;
            gap_cnt         <= '0;
            in_gap          <= 1'b0;
            past_end        <= 1'b0;
            py              <= '0;
            cell_y          <= '0;
            y_out           <= 1'b0;
            frame_cnt       <= '0;
            blink_phase     <= 1'b0;
            started         <= 1'b0;
            s1_valid        <= 1'b0;
            s1_blink        <= 1'b0;
            s1_orient       <= 1'b0;
            s1_mode         <= '0;
            s1_own_board    <= '0;
            s1_cursor_board <= '0;
            s1_cursor_x     <= '0;
            s1_cursor_y     <= '0;
            s1_ship_len     <= '0;
        end else begin
            s1_valid <= pix_en;
            if (pix_en) begin
                px              <= n_px;
                cell_x          <= n_cell_x;
                board           <= n_board;
                gap_cnt         <= n_gap;
                in_gap          <= n_in_gap;
                past_end        <= n_past_end;
                py              <= n_py;
                cell_y          <= n_cell_y;
                y_out           <= n_y_out;
                frame_cnt       <= n_frame_cnt;
                blink_phase     <= n_blink;
                started         <= n_started;
                s1_blink        <= n_blink;
                s1_orient       <= orient;
                s1_mode         <= mode;
                s1_own_board    <= own_board;
                s1_cursor_board <= cursor_board;
                s1_cursor_x     <= cursor_x;
                s1_cursor_y     <= cursor_y;
                s1_ship_len     <= ship_len;
            end
        end
    end

    assign rd_board = board;
    assign rd_row   = cell_y;
    assign rd_col   = cell_x;

    logic    is_attack, is_place, on_cb, covered, fits;
    logic [4:0] end_x, end_y;
    cursor_t cur_kind;

    // Cursor classification; mode 11 falls through to placement.
    always_comb begin
        is_attack = (s1_mode == 2'b01);
        is_place  = (s1_mode != 2'b01) && (s1_mode != 2'b10);
        on_cb     = (board == s1_cursor_board);
        end_x     = {1'b0, s1_cursor_x} + {1'b0, s1_ship_len};
        end_y     = {1'b0, s1_cursor_y} + {1'b0, s1_ship_len};
        if (s1_orient) begin
            covered = on_cb && (cell_x == s1_cursor_x) && (cell_y >= s1_cursor_y)
                      && ({1'b0, cell_y} < end_y);
            fits    = (end_y <= 5'(GRID_ROWS));
        end else begin
            covered = on_cb && (cell_y == s1_cursor_y) && (cell_x >= s1_cursor_x)
                      && ({1'b0, cell_x} < end_x);
            fits    = (end_x <= 5'(GRID_COLS));
        end
        cur_kind = CUR_NONE;
        if (is_attack && on_cb && (cell_x == s1_cursor_x) && (cell_y == s1_cursor_y))
            cur_kind = CUR_ATTACK;
        else if (is_place && s1_blink && covered)
            cur_kind = fits ? CUR_FIT : CUR_BAD;
    end

    // Stage 2 holds the pixel's classification while the RAM returns its cell code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_oog    <= 1'b0;
            s2_line   <= 1'b0;
            s2_fog    <= 1'b0;
            s2_blink  <= 1'b0;
            s2_cursor <= CUR_NONE;
        end else begin
            s2_valid  <= s1_valid;
            s2_oog    <= in_gap || past_end || y_out;
            s2_line   <= (px == '0) || (py == '0);
            s2_fog    <= is_attack && (board != s1_own_board);
            s2_blink  <= s1_blink;
            s2_cursor <= cur_kind;
        end
    end

    logic [11:0] colour;

    always_comb begin
        colour = 12'h000;
        if (s2_oog) begin
            colour = 12'h000;
        end else if (s2_line) begin
            colour = 12'h888;
        end else if (s2_cursor == CUR_ATTACK) begin
            colour = 12'hFFF;
        end else if ((s2_cursor != CUR_NONE) && (cell_t'(rd_data) == CELL_EMPTY)) begin
            colour = (s2_cursor == CUR_FIT) ? 12'hCC0 : 12'hC00;
        end else begin
            case (cell_t'(rd_data))
                CELL_EMPTY: colour = 12'h000;
                CELL_SHIP:  colour = s2_fog ? 12'h000 : 12'h0F0;
                CELL_HIT:   colour = s2_blink ? 12'hF80 : 12'hF00;
                CELL_MISS:  colour = 12'h00C;
                default:    colour = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_valid <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            rgb_valid <= s2_valid;
            vga_r     <= colour[11:8];
            vga_g     <= colour[7:4];
            vga_b     <= colour[3:0];
        end
    end

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: short frames reach chosen pixels via sof/sol,
// a behavioural board RAM answers reads one cycle late, colours are checked by hand values.
module tb_grid_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0, sof = 1'b0, sol = 1'b0;
    logic [1:0] mode = 2'b10;
    logic       own_board = 1'b0, cursor_board = 1'b0;
    logic [3:0] cursor_x = 4'd0, cursor_y = 4'd0, ship_len = 4'd0;
    logic       orient = 1'b0;
    logic       rd_board;
    logic [3:0] rd_row, rd_col;
    logic [1:0] rd_data = 2'b00;
    logic       rgb_valid;
    logic [3:0] vga_r, vga_g, vga_b;

    logic [1:0] mem [0:1][0:9][0:9];
    int         checks = 0;
    int         failures = 0;

    grid_renderer dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sof(sof), .sol(sol),
        .mode(mode), .own_board(own_board), .cursor_board(cursor_board),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .ship_len(ship_len), .orient(orient),
        .rd_board(rd_board), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .rgb_valid(rgb_valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    // Board RAM model with one cycle of read latency.
    always @(posedge clk) rd_data <= mem[rd_board][rd_row][rd_col];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic fillMem(input logic [1:0] code);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++)
                    mem[b][r][c] = code;
    endtask

    task automatic pixel(input logic s, input logic l);
        pix_en = 1'b1;
        sof = s;
        sol = l;
        @(negedge clk);
    endtask

    // Starts a new frame and streams just enough pixels to land on (x,y).
    task automatic applyStimulus(input int x, input int y);
        pixel(1'b1, 1'b0);
        for (int i = 1; i <= y; i++) pixel(1'b0, 1'b1);
        for (int i = 1; i <= x; i++) pixel(1'b0, 1'b0);
        pix_en = 1'b0;
        sof = 1'b0;
        sol = 1'b0;
    endtask

    task automatic expectPixel(input string tag, input int x, input int y, input int exp_colour);
        applyStimulus(x, y);
        repeat (2) @(negedge clk);
        checkOutput({tag, " valid"}, int'(rgb_valid), 1);
        checkOutput(tag, int'({vga_r, vga_g, vga_b}), exp_colour);
    endtask

    task automatic nextFrame();
        pixel(1'b1, 1'b0);
        pix_en = 1'b0;
        sof = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  frame_idx;
        logic p [3];

        fillMem(2'b01);
        repeat (3) @(negedge clk);
        checkOutput("reset valid", int'(rgb_valid), 0);
        checkOutput("reset rgb", int'({vga_r, vga_g, vga_b}), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset rd", int'({rd_board, rd_row, rd_col}), 0);
        checkOutput("post-reset valid", int'(rgb_valid), 0);

        // Reveal mode, ships everywhere.
        frame_idx = -1;
        mode = 2'b10;
        expectPixel("ship 33,33", 33, 33, 12'h0F0);             frame_idx++;
        expectPixel("line 32,40", 32, 40, 12'h888);             frame_idx++;
        expectPixel("gap 330,33", 330, 33, 12'h000);            frame_idx++;
        applyStimulus(385, 33);                                  frame_idx++;
        checkOutput("rd board1 cell 1,1", int'({rd_board, rd_row, rd_col}), 9'h111);
        repeat (2) @(negedge clk);
        checkOutput("ship board1", int'({vga_r, vga_g, vga_b}), 12'h0F0);
        expectPixel("below grid", 33, 320, 12'h000);            frame_idx++;
        expectPixel("right of boards", 672, 5, 12'h000);        frame_idx++;

        // Placement cursor on an empty board, blink phase still 0.
        fillMem(2'b00);
        mode = 2'b00; cursor_board = 1'b0; cursor_x = 4'd8; cursor_y = 4'd2;
        ship_len = 4'd3; orient = 1'b0;
        expectPixel("place blink0", 261, 69, 12'h000);          frame_idx++;
        while (frame_idx < 29) begin
            nextFrame();
            frame_idx++;
        end
        expectPixel("place bad cell8", 261, 69, 12'hC00);
        expectPixel("place bad cell9", 293, 69, 12'hC00);
        expectPixel("place off-cursor", 165, 69, 12'h000);
        cursor_x = 4'd7;
        expectPixel("place fit cell8", 261, 69, 12'hCC0);
        expectPixel("place fit cell7", 229, 69, 12'hCC0);
        mode = 2'b11;
        expectPixel("mode11 as place", 261, 69, 12'hCC0);
        mem[0][2][8] = 2'b11;
        expectPixel("place keeps miss", 261, 69, 12'h00C);
        mem[0][2][8] = 2'b00;
        orient = 1'b1; cursor_x = 4'd2; cursor_y = 4'd8;
        expectPixel("place vertical bad", 69, 261, 12'hC00);
        mode = 2'b10;
        expectPixel("reveal no cursor", 69, 261, 12'h000);

        // Attack mode: fog on the enemy board, white cursor cell.
        mem[1][0][0] = 2'b01;
        mem[0][0][0] = 2'b01;
        mode = 2'b01; own_board = 1'b0; cursor_board = 1'b1;
        cursor_x = 4'd3; cursor_y = 4'd4; orient = 1'b0;
        expectPixel("attack fog", 353, 1, 12'h000);
        expectPixel("attack own ship", 1, 1, 12'h0F0);
        expectPixel("attack cursor", 449, 129, 12'hFFF);
        own_board = 1'b1;
        expectPixel("attack own board1", 353, 1, 12'h0F0);

        // Gapped pixel stream with a reset pulse mid-line.
        mode = 2'b10;
        @(negedge clk);
        p[0] = 1'b0; p[1] = 1'b0; p[2] = 1'b0;
        for (int c = 0; c < 42; c++) begin
            if (c == 20) begin
                reset = 1'b1;
                pix_en = 1'b0;
                #1;
                checkOutput("reset valid async", int'(rgb_valid), 0);
                checkOutput("reset rgb async", int'({vga_r, vga_g, vga_b}), 0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                p[0] = 1'b0; p[1] = 1'b0; p[2] = 1'b0;
                checkOutput("reset rd cleared", int'({rd_board, rd_row, rd_col}), 0);
            end
            checkOutput("stream valid", int'(rgb_valid), int'(p[2]));
            p[2] = p[1];
            p[1] = p[0];
            p[0] = (c % 3 == 0);
            pix_en = p[0];
            sof = 1'b0;
            sol = 1'b0;
            @(negedge clk);
        end
        pix_en = 1'b0;
        repeat (4) @(negedge clk);

        // HIT blink across 61 frames, counted from the reset above.
        fillMem(2'b00);
        mem[0][0][0] = 2'b10;
        for (int f = 0; f <= 60; f++) begin
            applyStimulus(1, 1);
            repeat (2) @(negedge clk);
            if (f <= 29)
                checkOutput($sformatf("hit frame %0d", f), int'({vga_r, vga_g, vga_b}), 12'hF00);
            else if (f <= 59)
                checkOutput($sformatf("hit frame %0d", f), int'({vga_r, vga_g, vga_b}), 12'hF80);
            else
                checkOutput($sformatf("hit frame %0d", f), int'({vga_r, vga_g, vga_b}), 12'hF00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
